// File: rtl/mem_copy_engine.sv
// Block-move initiator for the single-port data memory: copies len words src->dst, 3 cycles/word.
// Optional MEM_COPY_CHECKSUM_EN adds a running sum of the words written in the current copy.
module mem_copy_engine #(
  parameter int DATA_SZ    = 32,
  parameter int ADDRESS_SZ = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDRESS_SZ-1:0] src,
  input  logic [ADDRESS_SZ-1:0] dst,
  input  logic [ADDRESS_SZ:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDRESS_SZ-1:0] address,
  output logic [DATA_SZ-1:0]    data_in,
  output logic                  we,
  input  logic [DATA_SZ-1:0]    data_out
`ifdef MEM_COPY_CHECKSUM_EN
  ,
  output logic [DATA_SZ-1:0]    checksum
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    WRITE   = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t                state_reg;
  logic [ADDRESS_SZ-1:0] cur_src_reg;
  logic [ADDRESS_SZ-1:0] cur_dst_reg;
  logic [ADDRESS_SZ:0]   remaining_reg;

  // data_in doubles as the capture register: it is loaded from data_out at the end
  // of CAPTURE and held untouched until the next CAPTURE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cur_src_reg   <= '0;
      cur_dst_reg   <= '0;
      remaining_reg <= '0;
      address       <= '0;
      data_in       <= '0;
      we            <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
`ifdef MEM_COPY_CHECKSUM_EN
      checksum      <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            cur_src_reg   <= src;
            cur_dst_reg   <= dst;
            remaining_reg <= len;
            busy          <= 1'b1;
`ifdef MEM_COPY_CHECKSUM_EN
            checksum      <= '0;
`endif
            if (len == '0) begin
              state_reg <= DONE;
              done      <= 1'b1;
            end else begin
              state_reg <= READ;
              address   <= src;
            end
          end
        end
        READ: begin
          state_reg <= CAPTURE;
        end
        CAPTURE: begin
          state_reg <= WRITE;
          data_in   <= data_out;
          address   <= cur_dst_reg;
          we        <= 1'b1;
        end
        WRITE: begin
          we            <= 1'b0;
          cur_src_reg   <= cur_src_reg + 1'b1;
          cur_dst_reg   <= cur_dst_reg + 1'b1;
          remaining_reg <= remaining_reg - 1'b1;
`ifdef MEM_COPY_CHECKSUM_EN
          checksum      <= checksum + data_in;
`endif
          // remaining still holds the pre-decrement count here
          if (remaining_reg == (ADDRESS_SZ+1)'(1)) begin
            state_reg <= DONE;
            done      <= 1'b1;
          end else begin
            state_reg <= READ;
            address   <= cur_src_reg + 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          we        <= 1'b0;
          done      <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine against a registered-read data memory model.
// Build with MEM_COPY_CHECKSUM_EN to also exercise the checksum port.
module tb_mem_copy_engine;
  localparam int DW = 32;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] src, dst;
  logic [AW:0]   len;
  logic          busy, done, we;
  logic [AW-1:0] address;
  logic [DW-1:0] data_in, data_out;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  always #5 clk = ~clk;

  mem_copy_engine #(.DATA_SZ(DW), .ADDRESS_SZ(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src(src), .dst(dst), .len(len),
    .busy(busy), .done(done), .address(address), .data_in(data_in), .we(we),
    .data_out(data_out)
`ifdef MEM_COPY_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  // Data memory model with registered read; pokes only happen while the engine is idle.
  logic [DW-1:0] mem [0:1023];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;
  always @(posedge clk) begin
    if (we) mem[address] <= data_in;
    else if (pl_en) mem[pl_addr] <= pl_data;
    data_out <= mem[address];
  end

  int errors = 0;
  int checks = 0;
  int done_cyc, n_writes, n_done, busy_cyc;
  logic [AW-1:0] rd_addr [0:3];

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Pulses start, then samples every negedge; cycle k is the k-th negedge after the start edge.
  task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW:0] l,
                          input int inj_cyc, input int rst_cyc, input int budget);
    done_cyc = -1; n_writes = 0; n_done = 0; busy_cyc = 0;
    for (int i = 0; i < 4; i++) rd_addr[i] = '0;
    @(negedge clk);
    src = s; dst = d; len = l; start = 1'b1;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      if (cyc == 1 || cyc == inj_cyc + 1) start = 1'b0;
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (busy) busy_cyc++;
      if (we) n_writes++;
      if (cyc % 3 == 1 && (cyc - 1) / 3 < 4) rd_addr[(cyc-1)/3] = address;
      if (cyc == inj_cyc) begin
        src = 10'd50; dst = 10'd60; len = 11'd2; start = 1'b1;
      end
      if (cyc == rst_cyc) begin
        check_eq("rst_we_before", {31'b0, we}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_async_we", {31'b0, we}, 32'd0);
        check_eq("rst_async_busy", {31'b0, busy}, 32'd0);
        check_eq("rst_async_done", {31'b0, done}, 32'd0);
      end
    end
    $display("copy src=%0d dst=%0d len=%0d: done_cyc=%0d writes=%0d done_pulses=%0d busy_cycles=%0d",
             s, d, l, done_cyc, n_writes, n_done, busy_cyc);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; src = '0; dst = '0; len = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_busy", {31'b0, busy}, 32'd0);
    check_eq("reset_done", {31'b0, done}, 32'd0);
    check_eq("reset_we", {31'b0, we}, 32'd0);
    check_eq("reset_address", {22'b0, address}, 32'd0);
    check_eq("reset_data_in", data_in, 32'd0);
    rst_n = 1'b1;

    // Basic len=5 copy
    for (int i = 0; i < 5; i++) poke(AW'(i), DW'(2 * i));
    run_copy(10'd0, 10'd16, 11'd5, -10, -1, 20);
    for (int i = 0; i < 5; i++) check_eq("basic_dst", mem[16+i], DW'(2 * i));
    for (int i = 0; i < 5; i++) check_eq("basic_src_kept", mem[i], DW'(2 * i));
    check_eq("basic_writes", n_writes, 32'd5);
    check_eq("basic_done_cyc", done_cyc, 32'd16);
    check_eq("basic_done_pulses", n_done, 32'd1);
    check_eq("basic_busy_cycles", busy_cyc, 32'd16);
    check_eq("basic_busy_after", {31'b0, busy}, 32'd0);
`ifdef MEM_COPY_CHECKSUM_EN
    check_eq("basic_checksum", checksum, 32'd20);
`endif

    // Zero-length request
    run_copy(10'd5, 10'd7, 11'd0, -10, -1, 4);
    check_eq("len0_done_cyc", done_cyc, 32'd1);
    check_eq("len0_writes", n_writes, 32'd0);
    check_eq("len0_busy_cycles", busy_cyc, 32'd1);
    check_eq("len0_done_pulses", n_done, 32'd1);
`ifdef MEM_COPY_CHECKSUM_EN
    check_eq("len0_checksum", checksum, 32'd0);
`endif

    // Source address wrap 1023 -> 0
    poke(10'd1022, 32'hA); poke(10'd1023, 32'hB); poke(10'd0, 32'hC);
    run_copy(10'd1022, 10'd100, 11'd3, -10, -1, 12);
    check_eq("wrap_mem100", mem[100], 32'hA);
    check_eq("wrap_mem101", mem[101], 32'hB);
    check_eq("wrap_mem102", mem[102], 32'hC);
    check_eq("wrap_rd0", {22'b0, rd_addr[0]}, 32'd1022);
    check_eq("wrap_rd1", {22'b0, rd_addr[1]}, 32'd1023);
    check_eq("wrap_rd2", {22'b0, rd_addr[2]}, 32'd0);
    check_eq("wrap_done_cyc", done_cyc, 32'd10);

    // Overlapping forward copy smears the first word
    poke(10'd0, 32'h11); poke(10'd1, 32'h22); poke(10'd2, 32'h33); poke(10'd3, 32'h44);
    run_copy(10'd0, 10'd1, 11'd3, -10, -1, 12);
    check_eq("ovl_mem0", mem[0], 32'h11);
    check_eq("ovl_mem1", mem[1], 32'h11);
    check_eq("ovl_mem2", mem[2], 32'h11);
    check_eq("ovl_mem3", mem[3], 32'h11);

    // Start pulsed mid-copy is ignored
    for (int i = 0; i < 5; i++) poke(AW'(30 + i), DW'(32'h300 + i));
    poke(10'd50, 32'h5050); poke(10'd51, 32'h5151);
    poke(10'd60, 32'h0); poke(10'd61, 32'h0);
    run_copy(10'd30, 10'd40, 11'd5, 4, -1, 24);
    check_eq("mid_done_pulses", n_done, 32'd1);
    check_eq("mid_done_cyc", done_cyc, 32'd16);
    check_eq("mid_writes", n_writes, 32'd5);
    check_eq("mid_mem40", mem[40], 32'h300);
    check_eq("mid_mem44", mem[44], 32'h304);
    check_eq("mid_mem60", mem[60], 32'h0);
    check_eq("mid_mem61", mem[61], 32'h0);

    // Reset during the third WRITE of a len=5 copy
    for (int i = 0; i < 5; i++) poke(AW'(200 + i), DW'(32'h2000 + i));
    for (int i = 0; i < 5; i++) poke(AW'(300 + i), 32'hDEAD);
    run_copy(10'd200, 10'd300, 11'd5, -10, 9, 20);
    check_eq("rst_writes", n_writes, 32'd3);
    check_eq("rst_mem300", mem[300], 32'h2000);
    check_eq("rst_mem301", mem[301], 32'h2001);
    check_eq("rst_mem303", mem[303], 32'hDEAD);
    check_eq("rst_mem304", mem[304], 32'hDEAD);
    check_eq("rst_done_pulses", n_done, 32'd0);
`ifdef MEM_COPY_CHECKSUM_EN
    check_eq("rst_checksum", checksum, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Fresh copy after reset release
    poke(10'd400, 32'h77); poke(10'd401, 32'h88);
    run_copy(10'd400, 10'd410, 11'd2, -10, -1, 10);
    check_eq("fresh_mem410", mem[410], 32'h77);
    check_eq("fresh_mem411", mem[411], 32'h88);
    check_eq("fresh_done_cyc", done_cyc, 32'd7);
    check_eq("fresh_done_pulses", n_done, 32'd1);
`ifdef MEM_COPY_CHECKSUM_EN
    check_eq("fresh_checksum", checksum, 32'hFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
